// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter in front of one shared Gray-to-binary converter.
// The winner's Gray word is latched, converted, and returned with a valid/ready handshake.
module gray_conv_arbiter #(
  parameter int NREQ = 4,
  parameter int W = 3,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   gray_in,
  output logic [NREQ-1:0]     gnt,
  output logic [W-1:0]        bin_out,
  output logic                out_valid,
  output logic [IDW-1:0]      out_id,
  input  logic                out_ready,
  output logic                busy,
  output logic [7:0]          conv_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    RESP
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    gray_reg;
  logic [IDW-1:0]  last_id_reg;

  logic [W-1:0]    bin_next;
  logic [W-1:0]    sel_gray;
  logic [IDW-1:0]  win_idx;
  logic [IDW:0]    cand;
  logic            win_found;
  logic [NREQ-1:0] gnt_next;

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi < W; gi++) begin : g_conv
    assign bin_next[gi] = ^gray_reg[W-1:gi];
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign gnt_next[gi] = (win_idx == IDW'(gi));
  end

  // Scan from last_id+1 upward; cand is one bit wider so the wrap can be subtracted off.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_id_reg} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!win_found && req[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_gray = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        sel_gray = gray_in[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      gray_reg    <= '0;
      last_id_reg <= IDW'(NREQ - 1);
      gnt         <= '0;
      bin_out     <= '0;
      out_valid   <= 1'b0;
      out_id      <= '0;
      busy        <= 1'b0;
      conv_cnt    <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            gnt         <= gnt_next;
            gray_reg    <= sel_gray;
            out_id      <= win_idx;
            last_id_reg <= win_idx;
            busy        <= 1'b1;
            state_reg   <= CONV;
          end else begin
            gnt <= '0;
          end
        end
        CONV: begin
          gnt       <= '0;
          bin_out   <= bin_next;
          out_valid <= 1'b1;
          state_reg <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            conv_cnt  <= conv_cnt + 8'd1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Shares a single Gray-to-binary conversion datapath between NREQ requesters.
- Round-robin arbitration selects one requester at a time.
- The selected Gray code is latched, converted, and returned as a registered binary result with a valid/ready handshake tagged with the requester ID.
- Sits between the Gray-code producers (counters, encoders) and the binary-consuming logic in the lab datapath.

Parameters:
- NREQ, 4, number of requesters (2..8); IDW = clog2(NREQ)
- W, 3, Gray/binary word width (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester conversion request, level
- gray_in  in  NREQ*W  packed Gray words; requester i uses bits [i*W +: W]
- gnt  out  NREQ  one-hot grant, single-cycle pulse
- bin_out  out  W  converted binary result
- out_valid  out  1  bin_out/out_id valid
- out_id  out  IDW  index of the requester that owns bin_out
- out_ready  in  1  consumer accepts result
- busy  out  1  high whenever the FSM is not in IDLE
- conv_cnt  out  8  completed-conversion counter

Behaviour:
- One clock; reset is asynchronous and active-low. All outputs are registered.
- Reset values:
  - gnt=0, bin_out=0, out_valid=0, out_id=0, busy=0, conv_cnt=0
  - state=IDLE, internal gray_reg=0
  - last_id=NREQ-1, so requester 0 has top priority after reset
- Conversion, combinational on gray_reg:
  - b[W-1] = g[W-1]
  - b[i] = b[i+1] XOR g[i] for i = W-2 down to 0
- FSM states: IDLE, CONV, RESP.
- IDLE:
  - If req=0: remain in IDLE.
  - Otherwise, the winner is the first asserted req scanning from last_id+1 upward, wrapping modulo NREQ.
  - On that edge: gnt[winner]=1, gray_reg <= gray_in[winner], out_id <= winner, last_id <= winner, busy=1, go CONV.
- CONV:
  - gnt cleared.
  - bin_out <= conversion(gray_reg), out_valid <= 1, go RESP.
- RESP:
  - out_valid, bin_out and out_id are held stable until out_ready is sampled high.
  - On that edge: out_valid <= 0, busy <= 0, conv_cnt <= conv_cnt+1 (wraps 255->0), go IDLE.
  - bin_out keeps its last value after the handshake.
- Latency: req sampled at edge E0 -> gnt high after E0 -> out_valid high after E1.
- Minimum spacing between grants is 3 cycles with out_ready tied high.
- Requester rules:
  - gray_in must be stable while req is high; it is sampled only on the grant edge.
  - A req dropped before the grant is treated as withdrawn; no grant is issued.
  - A req still high in the next IDLE cycle is a new request and is rearbitrated normally. Because of round-robin, it does not win again if others are pending.
- req changes while in CONV or RESP are ignored; sampling happens only in IDLE.
- out_ready high while out_valid=0 has no effect.
- A single requester that is continuously asserted is granted every 3 cycles.
- Reset asserted mid-operation immediately clears all state and outputs. No partial result is delivered; the pointer returns to its reset value.

Test Plan:
- Reset and single request:
  - Stimulus: rst_n low then high; req=0001, gray_in[0]=111, out_ready=1.
  - Required: gnt=0001 for 1 cycle, then bin_out=101, out_valid=1, out_id=0; conv_cnt=1 after the handshake.
- Exhaustive conversion:
  - Stimulus: requester 2 presents all 8 Gray codes, one per transaction.
  - Required: 000->000, 001->001, 011->010, 010->011, 110->100, 111->101, 101->110, 100->111.
- Round-robin fairness:
  - Stimulus: req=1111 held; gray_in = 110/010/101/100 for requesters 0..3.
  - Required: grant order 0,1,2,3,0; outputs 100/011/110/111 with out_id 0,1,2,3.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid rises; req[1] asserted meanwhile.
  - Required: bin_out/out_id stable, busy=1, no gnt; gnt=0010 is issued 1 cycle after the handshake completes.
- Mid-operation reset:
  - Stimulus: rst_n pulled low during RESP with conv_cnt=3.
  - Required: out_valid, gnt, busy and conv_cnt go to 0 immediately; after release with req=1000|0001, requester 0 is granted first.
- Counter wrap and withdrawn request:
  - Stimulus: 256 completed handshakes; separately, a req[3] pulse that drops while the FSM is busy.
  - Required: conv_cnt reads 0 after the 256th handshake; requester 3 is never granted.
